// File: rtl/gf_mult_seq.sv
// Sequential integer / carry-less / GF(2^w) multiplier with a run-time operand width.
// Latency: result and op_finish after edge w+1 (modes 0/1/3) or edge 2w (mode 2).
// Backpressure: op_enable is level-held; dropping it mid-operation aborts, dropping it in DONE releases.
module gf_mult_seq #(
    parameter int DATA_WIDTH = 32,
    localparam int WW = $clog2(DATA_WIDTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      op_enable,
    input  logic [1:0]                op_mode,
    input  logic [WW-1:0]             in_width,
    input  logic [DATA_WIDTH-1:0]     in_mult_a,
    input  logic [DATA_WIDTH-1:0]     in_mult_b,
    input  logic [DATA_WIDTH:0]       in_poly,
    output logic [2*DATA_WIDTH-1:0]   out_mult_result,
    output logic                      op_busy,
    output logic                      op_finish
);
    localparam int CW = $clog2(2 * DATA_WIDTH) + 1;
    localparam int IW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, MULT, REDUCE, DONE} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                mode_q;
    logic [WW-1:0]             w_q;
    logic [DATA_WIDTH-1:0]     a_q, b_q;
    logic [DATA_WIDTH:0]       poly_q;
    logic [2*DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0]   result_q, res_d;
    logic                      load_res;

    logic [WW-1:0]             w_eff;
    logic [DATA_WIDTH-1:0]     op_mask;
    logic [CW-1:0]             w_ext;
    logic [2*DATA_WIDTH-1:0]   a_shift, p_shift, res_mask;

    // Operand width is clamped and masks derived before the start edge latches them.
    always_comb begin
        w_eff = in_width;
        if (in_width == '0 || in_width > WW'(DATA_WIDTH))
            w_eff = WW'(DATA_WIDTH);
        op_mask = ~({DATA_WIDTH{1'b1}} << w_eff);
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        load_res = 1'b0;
        w_ext    = CW'(w_q);
        a_shift  = {{DATA_WIDTH{1'b0}}, a_q} << cnt_q;
        p_shift  = {{(DATA_WIDTH-1){1'b0}}, poly_q} << (cnt_q - w_ext);
        res_mask = ~({(2*DATA_WIDTH){1'b1}} << w_q);
        case (state_q)
            IDLE: begin
                if (op_enable) begin
                    state_d = MULT;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            MULT: begin
                if (!op_enable) begin
                    state_d = IDLE;
                end else if (cnt_q < w_ext) begin
                    if (b_q[cnt_q[IW-1:0]])
                        acc_d = (mode_q == 2'd0) ? acc_q + a_shift : acc_q ^ a_shift;
                    cnt_d = cnt_q + CW'(1);
                end else if (mode_q == 2'd2 && w_q != WW'(1)) begin
                    state_d = REDUCE;
                    cnt_d   = (w_ext << 1) - CW'(2);
                end else begin
                    state_d  = DONE;
                    load_res = 1'b1;
                end
            end
            REDUCE: begin
                if (!op_enable) begin
                    state_d = IDLE;
                end else begin
                    if (acc_q[cnt_q[CW-2:0]])
                        acc_d = acc_q ^ p_shift;
                    if (cnt_q == w_ext) begin
                        state_d  = DONE;
                        load_res = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            DONE: begin
                if (!op_enable)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A residue keeps only w bits even if the polynomial lacked its x^w term.
        res_d = (mode_q == 2'd2) ? (acc_d & res_mask) : acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            w_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            poly_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && op_enable) begin
                mode_q <= op_mode;
                w_q    <= w_eff;
                a_q    <= in_mult_a & op_mask;
                b_q    <= in_mult_b & op_mask;
                poly_q <= in_poly;
            end
            if (load_res)
                result_q <= res_d;
        end
    end

    assign out_mult_result = result_q;
    assign op_busy         = (state_q == MULT) || (state_q == REDUCE);
    assign op_finish       = (state_q == DONE);

endmodule

// File: tb/tb_gf_mult_seq.sv
// Bench for gf_mult_seq: directed test-plan cases, abort, async reset and random operations.
module tb_gf_mult_seq;
    logic        clk;
    logic        rst_n;
    logic        op_enable;
    logic [1:0]  op_mode;
    logic [5:0]  in_width;
    logic [31:0] in_mult_a;
    logic [31:0] in_mult_b;
    logic [32:0] in_poly;
    logic [63:0] out_mult_result;
    logic        op_busy;
    logic        op_finish;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] sb_q[$];

    gf_mult_seq #(.DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .op_enable(op_enable),
        .op_mode(op_mode),
        .in_width(in_width),
        .in_mult_a(in_mult_a),
        .in_mult_b(in_mult_b),
        .in_poly(in_poly),
        .out_mult_result(out_mult_result),
        .op_busy(op_busy),
        .op_finish(op_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_width(input logic [5:0] w);
        return (w == 0 || w > 32) ? 32 : int'(w);
    endfunction

    function automatic logic [63:0] model(input logic [1:0] m, input logic [5:0] w,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [32:0] p);
        int          we;
        logic [63:0] mask, am, bm, acc, pe;
        we   = eff_width(w);
        mask = ~({64{1'b1}} << we);
        am   = {32'd0, a} & mask;
        bm   = {32'd0, b} & mask;
        if (m == 2'd0)
            return am * bm;
        acc = '0;
        for (int i = 0; i < we; i++)
            if (bm[i]) acc = acc ^ (am << i);
        if (m == 2'd2) begin
            pe = {31'd0, p};
            for (int j = 2 * we - 2; j >= we; j--)
                if (acc[j]) acc = acc ^ (pe << (j - we));
            acc = acc & mask;
        end
        return acc;
    endfunction

    function automatic int model_lat(input logic [1:0] m, input logic [5:0] w);
        return (m == 2'd2) ? 2 * eff_width(w) : eff_width(w) + 1;
    endfunction

    // Starts an operation, scrambles the inputs after the start edge, and waits for op_finish.
    task automatic run_op(input string tag, input logic [1:0] m, input logic [5:0] w,
                          input logic [31:0] a, input logic [31:0] b, input logic [32:0] p,
                          input logic [63:0] exp, input int exp_lat);
        int k;
        int busy_cnt;
        bit done;
        logic [63:0] want;
        @(negedge clk);
        op_mode   = m;
        in_width  = w;
        in_mult_a = a;
        in_mult_b = b;
        in_poly   = p;
        op_enable = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_busy0"}, 64'(op_busy), 64'd1);
        op_mode   = 2'($urandom);
        in_width  = 6'($urandom);
        in_mult_a = $urandom;
        in_mult_b = $urandom;
        in_poly   = {1'b1, 32'($urandom)};
        k = 0;
        busy_cnt = 0;
        done = 1'b0;
        while (!done && k < exp_lat + 8) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (op_finish) done = 1'b1;
            else if (op_busy) busy_cnt++;
        end
        check({tag, "_lat"}, done ? 64'(k) : 64'hFFFF, 64'(exp_lat));
        check({tag, "_busycnt"}, 64'(busy_cnt), 64'(exp_lat - 1));
        check({tag, "_busy_at_fin"}, 64'(op_busy), 64'd0);
        want = sb_q.pop_front();
        check({tag, "_res"}, out_mult_result, want);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_hold"}, {63'd0, op_finish}, 64'd1);
        op_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_release"}, {62'd0, op_busy, op_finish}, 64'd0);
        check({tag, "_res_keep"}, out_mult_result, want);
    endtask

    initial begin
        bit          fin_seen;
        logic [1:0]  rm;
        logic [5:0]  rw;
        logic [31:0] ra, rb;
        logic [32:0] rp;
        int          we;

        rst_n     = 1'b0;
        op_enable = 1'b0;
        op_mode   = '0;
        in_width  = '0;
        in_mult_a = '0;
        in_mult_b = '0;
        in_poly   = '0;
        #23;
        check("rst_res", out_mult_result, 64'd0);
        check("rst_busy", 64'(op_busy), 64'd0);
        check("rst_fin", 64'(op_finish), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("int8", 2'd0, 6'd8, 32'd200, 32'd100, 33'd0, 64'd20000, 9);
        run_op("clmul4", 2'd1, 6'd4, 32'hB, 32'h6, 33'd0, 64'h3A, 5);
        run_op("int4", 2'd0, 6'd4, 32'hB, 32'h6, 33'd0, 64'd66, 5);
        run_op("mode3", 2'd3, 6'd4, 32'hB, 32'h6, 33'd0, 64'h3A, 5);
        run_op("aes", 2'd2, 6'd8, 32'h57, 32'h83, 33'h11B, 64'hC1, 16);
        run_op("clamp", 2'd0, 6'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'd0, 64'hFFFFFFFE00000001, 33);
        run_op("mask4", 2'd0, 6'd4, 32'hFF, 32'h13, 33'd0, 64'd45, 5);
        run_op("gf_w1", 2'd2, 6'd1, 32'h1, 32'h1, 33'h3, 64'h1, 2);

        // Abort: result 0x1234 stays put when op_enable drops before edge 5.
        run_op("pre", 2'd0, 6'd16, 32'h1234, 32'h1, 33'd0, 64'h1234, 17);
        @(negedge clk);
        op_mode   = 2'd0;
        in_width  = 6'd16;
        in_mult_a = 32'hFFFF;
        in_mult_b = 32'hFFFF;
        op_enable = 1'b1;
        fin_seen  = 1'b0;
        @(posedge clk);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            @(negedge clk);
            fin_seen |= op_finish;
        end
        op_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        fin_seen |= op_finish;
        check("abort_busy", 64'(op_busy), 64'd0);
        check("abort_res", out_mult_result, 64'h1234);
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            fin_seen |= op_finish;
        end
        check("abort_nofin", 64'(fin_seen), 64'd0);
        run_op("restart", 2'd0, 6'd16, 32'hFFFF, 32'hFFFF, 33'd0, 64'hFFFE0001, 17);

        // Async reset in the middle of the reduction phase.
        @(negedge clk);
        op_mode   = 2'd2;
        in_width  = 6'd8;
        in_mult_a = 32'h57;
        in_mult_b = 32'h83;
        in_poly   = 33'h11B;
        op_enable = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 12; e++) @(posedge clk);
        #2;
        check("mid_busy", 64'(op_busy), 64'd1);
        rst_n     = 1'b0;
        op_enable = 1'b0;
        #1;
        check("arst_res", out_mult_result, 64'd0);
        check("arst_flags", {62'd0, op_busy, op_finish}, 64'd0);
        #1;
        rst_n = 1'b1;
        run_op("aes2", 2'd2, 6'd8, 32'h57, 32'h83, 33'h11B, 64'hC1, 16);

        for (int t = 0; t < 12; t++) begin
            rm = 2'($urandom);
            rw = (t % 4 == 3) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(1, 32));
            we = eff_width(rw);
            ra = $urandom;
            rb = $urandom;
            rp = ({1'b0, 32'($urandom)} & ~({33{1'b1}} << we)) | (33'd1 << we);
            run_op($sformatf("rnd%0d", t), rm, rw, ra, rb, rp,
                   model(rm, rw, ra, rb, rp), model_lat(rm, rw));
        end

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
